// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROR over SHW mux levels spread across STAGES
// register stages, valid/ready handshake with full backpressure.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SHW    = $clog2(WIDTH),
  parameter int unsigned STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] D,
  input  logic [SHW-1:0]   S,
  input  logic [1:0]       OP,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Y,
  output logic             CO
);

  typedef enum logic [1:0] {
    OpSll = 2'b00,
    OpSrl = 2'b01,
    OpSra = 2'b10,
    OpRor = 2'b11
  } op_e;

  // Stage that owns mux level lvl.
  function automatic int unsigned stage_of(input int unsigned lvl);
    return (lvl * STAGES) / SHW;
  endfunction

  function automatic logic [WIDTH-1:0] lvl_shift(input logic [WIDTH-1:0] x,
                                                  input logic [1:0]       op,
                                                  input int unsigned      amt);
    logic [WIDTH-1:0] r;
    case (op)
      OpSll:   r = x << amt;
      OpSrl:   r = x >> amt;
      OpSra:   r = $signed(x) >>> amt;
      default: r = (x >> amt) | (x << (WIDTH - amt));
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] data_q [STAGES];
  logic [WIDTH-1:0] data_d [STAGES];
  logic [SHW-1:0]   sh_q   [STAGES];
  logic [SHW-1:0]   sh_d   [STAGES];
  logic [1:0]       op_q   [STAGES];
  logic [1:0]       op_d   [STAGES];
  logic [STAGES-1:0] vld_q, co_q, adv;

  // Per-stage inputs: stage 0 takes the ports, stage k takes register k-1.
  logic [WIDTH-1:0]  sin_data [STAGES];
  logic [SHW-1:0]    sin_sh   [STAGES];
  logic [1:0]        sin_op   [STAGES];
  logic [STAGES-1:0] sin_vld, sin_co;

  logic [SHW-1:0] s_neg, s_dec;
  logic           co_first;

  // Last bit shifted out; for ROR this equals Y[WIDTH-1], i.e. D[S-1].
  assign s_neg    = -S;
  assign s_dec    = S - SHW'(1);
  assign co_first = (S == '0) ? 1'b0 : ((OP == OpSll) ? D[s_neg] : D[s_dec]);

  always_comb begin
    sin_data[0] = D;
    sin_sh[0]   = S;
    sin_op[0]   = OP;
    sin_vld[0]  = IN_VALID;
    sin_co[0]   = co_first;
    for (int unsigned k = 1; k < STAGES; k++) begin
      sin_data[k] = data_q[k-1];
      sin_sh[k]   = sh_q[k-1];
      sin_op[k]   = op_q[k-1];
      sin_vld[k]  = vld_q[k-1];
      sin_co[k]   = co_q[k-1];
    end
  end

  always_comb begin
    logic [WIDTH-1:0] cur;
    logic [SHW-1:0]   cur_s;
    logic [1:0]       cur_op;
    int unsigned      st;
    for (int unsigned k = 0; k < STAGES; k++) begin
      data_d[k] = sin_data[k];
      sh_d[k]   = sin_sh[k];
      op_d[k]   = sin_op[k];
    end
    cur    = D;
    cur_s  = S;
    cur_op = OP;
    st     = 0;
    for (int unsigned i = 0; i < SHW; i++) begin
      st = stage_of(i);
      if (i == 0 || st != stage_of(i - 1)) begin
        cur    = sin_data[st];
        cur_s  = sin_sh[st];
        cur_op = sin_op[st];
      end
      if (cur_s[i]) begin
        cur = lvl_shift(cur, cur_op, 32'd1 << i);
      end
      data_d[st] = cur;
      sh_d[st]   = cur_s;
      op_d[st]   = cur_op;
    end
  end

  // adv[k] = !vld[k] | adv[k+1], flattened so no bit depends on another.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      adv[k] = OUT_READY;
      for (int unsigned j = k; j < STAGES; j++) begin
        if (!vld_q[j]) begin
          adv[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q <= '0;
      co_q  <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        sh_q[k]   <= '0;
        op_q[k]   <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          vld_q[k] <= sin_vld[k];
          // Payload only loads with valid data so Y keeps its last result across bubbles.
          if (sin_vld[k]) begin
            data_q[k] <= data_d[k];
            sh_q[k]   <= sh_d[k];
            op_q[k]   <= op_d[k];
            co_q[k]   <= sin_co[k];
          end
        end
      end
    end
  end

  assign IN_READY  = adv[0];
  assign OUT_VALID = vld_q[STAGES-1];
  assign Y         = data_q[STAGES-1];
  assign CO        = co_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: directed table plus stall/reset sequences at
// WIDTH=32/STAGES=2, and random scoreboard runs at 8/1, 8/3 and 64/6.
module tb_pipelined_barrel_shifter;

  localparam int NCFG = 4;
  localparam int CW[NCFG] = '{32, 8, 8, 64};
  localparam int CS[NCFG] = '{2, 1, 3, 6};
  localparam int NOPS = 1000;
  localparam int NVEC = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input int cfg, input string name, input logic [63:0] act,
                     input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL cfg%0d %s: got %0h want %0h", cfg, name, act, want);
    end
  endtask

  // Independent bit-level model: returns {co, y}.
  function automatic logic [64:0] ref_model(input logic [63:0] d, input int w, input int s,
                                            input logic [1:0] op);
    logic [63:0] y;
    logic        co;
    y = '0;
    for (int j = 0; j < w; j++) begin
      case (op)
        2'b00:   y[j] = (j >= s) ? d[j-s] : 1'b0;
        2'b01:   y[j] = (j + s < w) ? d[j+s] : 1'b0;
        2'b10:   y[j] = (j + s < w) ? d[j+s] : d[w-1];
        default: y[j] = d[(j+s)%w];
      endcase
    end
    if (s == 0) co = 1'b0;
    else if (op == 2'b00) co = d[w-s];
    else co = d[s-1];
    return {co, y};
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [31:0] d;
    logic [4:0]  s;
    logic [31:0] y;
    logic        co;
  } vec_t;

  vec_t vecs[NVEC];

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W  = CW[g];
    localparam int ST = CS[g];
    localparam int SW = $clog2(W);

    typedef struct {
      logic [W-1:0] y;
      logic         co;
      int           acc;
      bit           seen;
    } item_t;

    logic          rst, in_valid, in_ready, out_valid, out_ready, co;
    logic [W-1:0]  d, y;
    logic [SW-1:0] s;
    logic [1:0]    op;
    item_t         q[$];
    int            cyc = 0;
    int            last_stall = -1;
    int            ncons = 0;
    bit            fired = 1'b0;
    bit            done = 1'b0;

    pipelined_barrel_shifter #(.WIDTH(W), .STAGES(ST)) dut (
      .CLK      (clk),
      .RST      (rst),
      .IN_VALID (in_valid),
      .IN_READY (in_ready),
      .D        (d),
      .S        (s),
      .OP       (op),
      .OUT_VALID(out_valid),
      .OUT_READY(out_ready),
      .Y        (y),
      .CO       (co)
    );

    // Scoreboard: at each negedge, predict what the next posedge will do.
    always @(negedge clk) begin
      logic [64:0] r;
      item_t       h;
      fired = 1'b0;
      if (rst) begin
        q.delete();
      end else begin
        if (out_valid) begin
          if (q.size() == 0) begin
            chk(g, "unexpected output", 1, 0);
          end else begin
            h = q[0];
            if (!h.seen) begin
              h.seen = 1'b1;
              q[0]   = h;
              if (last_stall <= h.acc) chk(g, "latency", 64'(cyc - h.acc), 64'(ST));
              else chk(g, "latency min", 64'(cyc - h.acc >= ST), 1);
            end
            if (out_ready) begin
              chk(g, "y", 64'(y), 64'(h.y));
              chk(g, "co", 64'(co), 64'(h.co));
              void'(q.pop_front());
              ncons++;
            end
          end
        end
        if (!out_ready) last_stall = cyc;
        if (in_valid && in_ready) begin
          r = ref_model(64'(d), W, int'(s), op);
          q.push_back('{y: r[W-1:0], co: r[64], acc: cyc, seen: 1'b0});
          fired = 1'b1;
        end
        if (q.size() > ST) chk(g, "occupancy", 64'(q.size()), 64'(ST));
      end
      cyc++;
    end

    if (g == 0) begin : g_dir
      initial begin
        logic [W-1:0] held_y;
        logic         held_co;
        int           k, cons0;
        vecs[0]  = '{2'b00, 32'h0000000F, 5'd2,  32'h0000003C, 1'b0};
        vecs[1]  = '{2'b01, 32'h80000010, 5'd5,  32'h04000000, 1'b1};
        vecs[2]  = '{2'b10, 32'h80000010, 5'd4,  32'hF8000001, 1'b0};
        vecs[3]  = '{2'b11, 32'h0000000F, 5'd4,  32'hF0000000, 1'b1};
        vecs[4]  = '{2'b00, 32'hFFFFFFFF, 5'd31, 32'h80000000, 1'b1};
        vecs[5]  = '{2'b10, 32'h7FFFFFFF, 5'd31, 32'h00000000, 1'b1};
        vecs[6]  = '{2'b00, 32'h12345678, 5'd0,  32'h12345678, 1'b0};
        vecs[7]  = '{2'b01, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0};
        vecs[8]  = '{2'b10, 32'h80000001, 5'd0,  32'h80000001, 1'b0};
        vecs[9]  = '{2'b11, 32'hA5A5A5A5, 5'd0,  32'hA5A5A5A5, 1'b0};
        vecs[10] = '{2'b11, 32'h00000001, 5'd1,  32'h80000000, 1'b1};
        vecs[11] = '{2'b01, 32'hFFFFFFFF, 5'd31, 32'h00000001, 1'b1};
        vecs[12] = '{2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0};
        vecs[13] = '{2'b11, 32'h12345678, 5'd8,  32'h78123456, 1'b0};
        vecs[14] = '{2'b00, 32'h80000001, 5'd1,  32'h00000002, 1'b1};
        vecs[15] = '{2'b11, 32'h80000000, 5'd31, 32'h00000001, 1'b0};

        // Reset held with a valid input present.
        rst = 1'b1; in_valid = 1'b1; d = '1; s = 3; op = 2'b00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk(g, "rst out_valid", 64'(out_valid), 0);
        chk(g, "rst y", 64'(y), 0);
        chk(g, "rst co", 64'(co), 0);
        rst = 1'b0; in_valid = 1'b0;
        #1 chk(g, "rst in_ready", 64'(in_ready), 1);
        for (int c = 0; c < 3; c++) begin
          @(posedge clk); #1;
          chk(g, "nothing accepted", 64'(out_valid), 0);
        end

        // Directed table, back to back.
        for (int j = 0; j < NVEC + ST; j++) begin
          if (j < NVEC) begin
            in_valid = 1'b1; op = vecs[j].op; d = vecs[j].d; s = vecs[j].s;
          end else begin
            in_valid = 1'b0;
          end
          #1;
          if (j < NVEC) chk(g, "tbl in_ready", 64'(in_ready), 1);
          if (j >= ST) begin
            chk(g, "tbl out_valid", 64'(out_valid), 1);
            chk(g, "tbl y", 64'(y), 64'(vecs[j-ST].y));
            chk(g, "tbl co", 64'(co), 64'(vecs[j-ST].co));
          end else begin
            chk(g, "tbl early out_valid", 64'(out_valid), 0);
          end
          @(posedge clk); #1;
        end
        chk(g, "tbl drained", 64'(out_valid), 0);

        // Six ops with a five-cycle stall in the middle.
        cons0 = ncons;
        k = 0;
        for (int c = 0; c < 40; c++) begin
          if (fired) k++;
          if (k < 6) begin
            if (c == 0 || fired) begin
              in_valid = 1'b1; d = $urandom(); s = 5'($urandom_range(31));
              op = 2'($urandom_range(3));
            end
          end else begin
            in_valid = 1'b0;
          end
          out_ready = !(c >= 3 && c < 8);
          #1;
          if (c == 3) begin
            held_y  = y;
            held_co = co;
            chk(g, "stall out_valid", 64'(out_valid), 1);
          end
          if (c > 3 && c < 8) begin
            chk(g, "stall y", 64'(y), 64'(held_y));
            chk(g, "stall co", 64'(co), 64'(held_co));
            chk(g, "stall out_valid", 64'(out_valid), 1);
            chk(g, "stall in_ready", 64'(in_ready), 0);
            chk(g, "stall buffered", 64'(q.size()), 64'(ST));
          end
          @(posedge clk); #1;
        end
        chk(g, "stall consumed", 64'(ncons - cons0), 6);

        // Two ops in flight, then reset.
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
          in_valid = 1'b1; d = $urandom(); s = 5'($urandom_range(1, 31));
          op = 2'($urandom_range(3));
          #1 chk(g, "mid in_ready", 64'(in_ready), 1);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk(g, "mid out_valid", 64'(out_valid), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk(g, "mid rst out_valid", 64'(out_valid), 0);
        chk(g, "mid rst y", 64'(y), 0);
        chk(g, "mid rst co", 64'(co), 0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
          @(posedge clk); #1;
          chk(g, "mid discarded", 64'(out_valid), 0);
        end
        done = 1'b1;
      end
    end else begin : g_rnd
      initial begin
        int  n, c;
        bit  first;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; d = '0; s = '0; op = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n = 0; c = 0; first = 1'b1;
        while (n < NOPS && c < 20000) begin
          if (fired) n++;
          if (first || fired || !in_valid) begin
            first = 1'b0;
            if (n < NOPS) begin
              in_valid = ($urandom_range(3) != 0);
              d  = W'({$urandom(), $urandom()});
              s  = SW'($urandom_range(W - 1));
              op = 2'($urandom_range(3));
            end else begin
              in_valid = 1'b0;
            end
          end
          out_ready = ($urandom_range(3) != 0);
          @(posedge clk); #1;
          c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) begin
          @(posedge clk); #1;
        end
        chk(g, "accepted", 64'(n), 64'(NOPS));
        chk(g, "drained", 64'(q.size()), 0);
        chk(g, "consumed", 64'(ncons), 64'(NOPS));
        done = 1'b1;
      end
    end
  end

  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int c = 0; c < 30000 && !all_done; c++) begin
      @(posedge clk);
      all_done = g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done;
    end
    if (!all_done) chk(-1, "timeout", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined barrel shifter. Successor to the fixed 32-bit combinational left, right and LnR shifters. Supports four shift modes, a configurable width, and a configurable number of register stages. Uses a valid/ready handshake with full backpressure, and sits between the ALU operand mux and the writeback register.

Parameters:
WIDTH, 32, data width; power of two, 8..64
SHW, $clog2(WIDTH), shift-amount width (derived; do not override)
STAGES, 2, pipeline register stages, 1..SHW

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous, active-high reset
IN_VALID  input  1  input transaction present
IN_READY  output  1  block can accept input this cycle
D  input  WIDTH  operand
S  input  SHW  shift amount, 0..WIDTH-1
OP  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
OUT_VALID  output  1  Y/CO hold a result
OUT_READY  input  1  consumer accepts result this cycle
Y  output  WIDTH  shifted result (registered)
CO  output  1  last bit shifted out (registered)

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high. On any edge with RST=1:
  - all stage valid bits clear
  - Y=0, CO=0, OUT_VALID=0
  - in-flight transactions are discarded
  - IN_READY=1 in the first cycle after RST deasserts
- Datapath:
  - SHW mux levels; level i shifts by 2^i when S[i]=1.
  - Level i is placed in stage floor(i*STAGES/SHW). Each stage ends in a register holding data, remaining S bits, OP, CO and a valid bit.
- Modes:
  - SLL: zero fill at LSB.
  - SRL: zero fill at MSB.
  - SRA: D[WIDTH-1] replicated at MSB.
  - ROR: rotate right, no fill.
- CO:
  - S=0: CO=0 (all modes).
  - SLL: CO=D[WIDTH-S].
  - SRL/SRA: CO=D[S-1].
  - ROR: CO=Y[WIDTH-1].
  - CO is computed in stage 1 and carried along the pipeline.
- Handshake:
  - Input is accepted on an edge with IN_VALID & IN_READY.
  - Output is consumed on an edge with OUT_VALID & OUT_READY.
  - Stage k advances when it holds no valid data or stage k+1 advances; the output stage advances when OUT_READY=1 or OUT_VALID=0.
  - IN_READY = stage-1 advance condition. It is combinational from OUT_READY; there is no combinational path from IN_VALID to IN_READY.
- Latency and throughput:
  - Latency is STAGES cycles: data accepted at edge t drives OUT_VALID=1 after edge t+STAGES-1, provided there is no stall.
  - Throughput is 1 per cycle when OUT_READY stays 1.
- Stall: while OUT_VALID=1 and OUT_READY=0:
  - Y, CO and OUT_VALID hold stable.
  - Upstream bubbles are squeezed out before IN_READY drops.
  - The pipeline holds at most STAGES results.
- Ordering and integrity: results exit in acceptance order, with no loss or duplication.
- Simultaneous events:
  - Consuming and accepting on the same edge in a full pipe is legal and keeps the pipe full.
  - RST has priority over all handshakes.
- Boundaries:
  - S=0 gives Y=D, CO=0.
  - S=WIDTH-1 is the maximum shift.
  - OP and S are only sampled on acceptance; changes while IN_READY=0 have no effect.

Test Plan:
- Reset/basic, WIDTH=32, STAGES=2:
  - Assert RST 2 cycles with IN_VALID=1 -> OUT_VALID=0, Y=0, CO=0, nothing accepted.
  - Then SLL D=0x0000000F S=2 -> Y=0x0000003C, CO=0, OUT_VALID 2 cycles after acceptance.
- Modes, back-to-back with OUT_READY=1:
  - SRL 0x80000010 S=5 -> 0x04000000, CO=1
  - SRA 0x80000010 S=4 -> 0xF8000001, CO=0
  - ROR 0x0000000F S=4 -> 0xF0000000, CO=1
  - All results appear on consecutive cycles.
- Extremes:
  - SLL 0xFFFFFFFF S=31 -> 0x80000000, CO=1
  - SRA 0x7FFFFFFF S=31 -> 0x00000000, CO=1
  - any OP with S=0 -> Y=D, CO=0
- Backpressure: stream 6 random ops, hold OUT_READY=0 for 5 cycles mid-stream:
  - IN_READY drops once STAGES results are buffered.
  - Y/CO are stable while stalled.
  - All 6 results match a reference model, in order.
- Reset mid-flight: accept 2 ops, assert RST before either is consumed -> both discarded, OUT_VALID=0 next cycle.
- Parameter sweep: WIDTH=8 with STAGES=1 and STAGES=3; WIDTH=64 with STAGES=6; 1000 random ops each with random OUT_READY -> scoreboard match, latency equal to STAGES when unstalled.
